// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and instruction field positions for the ALU issue controller.
// Build option ALU_ISSUE_FLAGS_EN (see alu_issue_ctrl) adds zero / divide-by-zero result flags.
package alu_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int REG_AW     = 2;

    localparam logic [3:0] OP_LDI      = 4'b0000;
    localparam logic [3:0] OP_ADD      = 4'b0001;
    localparam logic [3:0] OP_SUBTRACT = 4'b0010;
    localparam logic [3:0] OP_MULTIPLY = 4'b0011;
    localparam logic [3:0] OP_DIVIDE   = 4'b0100;
    localparam logic [3:0] OP_AND      = 4'b0101;
    localparam logic [3:0] OP_OR       = 4'b0110;
    localparam logic [3:0] OP_NOT_OP1  = 4'b0111;
    localparam logic [3:0] OP_NOT_OP2  = 4'b1000;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS1_MSB = 9;
    localparam int RS1_LSB = 8;
    localparam int RS2_MSB = 7;
    localparam int RS2_LSB = 6;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_NOT_OP2);
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 4x8 register file: two asynchronous read ports, one synchronous write port.
// Synchronous active-high reset clears every entry; reset wins over a same-cycle write.
module alu_issue_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction at a time to an external combinational ALU and writes the result back.
// Latency: ALU op res_valid 2 cycles after accept, LDI 1 cycle; result held until res_ready.
// Optional ALU_ISSUE_FLAGS_EN adds res_zero / res_divz outputs, valid with res_valid.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [3:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_operand1,
    output logic [DATA_W-1:0] alu_operand2,
    input  logic [DATA_W-1:0] alu_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [REG_AW-1:0] res_rd,
    output logic              illegal
`ifdef ALU_ISSUE_FLAGS_EN
    ,
    output logic              res_zero,
    output logic              res_divz
`endif
);

    state_t              state_q, state_d;
    logic [3:0]          opc_q, opc_d;
    logic [DATA_W-1:0]   op1_q, op1_d;
    logic [DATA_W-1:0]   op2_q, op2_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic                illegal_q, illegal_d;
    logic                wb_first_q, wb_first_d;
`ifdef ALU_ISSUE_FLAGS_EN
    logic                divz_q, divz_d;
`endif

    logic [3:0]          in_op;
    logic [DATA_W-1:0]   rf_rdata1, rf_rdata2;
    logic                rf_we;

    assign in_op = instr[OP_MSB:OP_LSB];

    // Operands are read straight from the incoming instruction so they can be
    // registered at accept time and stay stable throughout EXEC.
    alu_issue_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we_i     (rf_we),
        .waddr_i  (rd_q),
        .wdata_i  (res_data_q),
        .raddr1_i (instr[RS1_MSB:RS1_LSB]),
        .raddr2_i (instr[RS2_MSB:RS2_LSB]),
        .rdata1_o (rf_rdata1),
        .rdata2_o (rf_rdata2)
    );

    assign rf_we = (state_q == ST_WB) && wb_first_q;

    always_comb begin
        state_d    = state_q;
        opc_d      = 4'b0000;
        op1_d      = op1_q;
        op2_d      = op2_q;
        res_data_d = res_data_q;
        rd_d       = rd_q;
        illegal_d  = 1'b0;
        wb_first_d = 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
        divz_d     = divz_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (in_op == OP_LDI) begin
                        rd_d       = instr[RD_MSB:RD_LSB];
                        res_data_d = instr[IMM_MSB:IMM_LSB];
                        wb_first_d = 1'b1;
                        state_d    = ST_WB;
`ifdef ALU_ISSUE_FLAGS_EN
                        divz_d     = 1'b0;
`endif
                    end else if (is_alu_op(in_op)) begin
                        rd_d    = instr[RD_MSB:RD_LSB];
                        opc_d   = in_op;
                        op1_d   = rf_rdata1;
                        op2_d   = rf_rdata2;
                        state_d = ST_EXEC;
`ifdef ALU_ISSUE_FLAGS_EN
                        divz_d  = (in_op == OP_DIVIDE) && (rf_rdata2 == '0);
`endif
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                res_data_d = alu_result;
                wb_first_d = 1'b1;
                state_d    = ST_WB;
            end
            ST_WB: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            opc_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            res_data_q <= '0;
            rd_q       <= '0;
            illegal_q  <= 1'b0;
            wb_first_q <= 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
            divz_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            opc_q      <= opc_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            res_data_q <= res_data_d;
            rd_q       <= rd_d;
            illegal_q  <= illegal_d;
            wb_first_q <= wb_first_d;
`ifdef ALU_ISSUE_FLAGS_EN
            divz_q     <= divz_d;
`endif
        end
    end

    // Gated with rst so nothing is offered while reset is held.
    assign instr_ready  = (state_q == ST_IDLE) && !rst;
    assign alu_opcode   = opc_q;
    assign alu_operand1 = op1_q;
    assign alu_operand2 = op2_q;
    assign res_valid    = (state_q == ST_WB);
    assign res_data     = res_data_q;
    assign res_rd       = rd_q;
    assign illegal      = illegal_q;
`ifdef ALU_ISSUE_FLAGS_EN
    assign res_zero     = (state_q == ST_WB) && (res_data_q == '0);
    assign res_divz     = (state_q == ST_WB) && divz_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed vectors plus randomized instruction stream vs a register-file model.
// Also covers ALU_ISSUE_FLAGS_EN outputs when that macro is defined.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [3:0]  alu_opcode;
    logic [7:0]  alu_operand1;
    logic [7:0]  alu_operand2;
    logic [7:0]  alu_result;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic [1:0]  res_rd;
    logic        illegal;
`ifdef ALU_ISSUE_FLAGS_EN
    logic        res_zero;
    logic        res_divz;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mdl [4];
    logic [7:0]  last_res;
    time         acc_time;

    alu_issue_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .alu_opcode   (alu_opcode),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_result   (alu_result),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_rd       (res_rd),
        .illegal      (illegal)
`ifdef ALU_ISSUE_FLAGS_EN
        ,
        .res_zero     (res_zero),
        .res_divz     (res_divz)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment ALU (combinational), as it would sit next to the controller.
    always_comb begin
        case (alu_opcode)
            OP_ADD:      alu_result = alu_operand1 + alu_operand2;
            OP_SUBTRACT: alu_result = alu_operand1 - alu_operand2;
            OP_MULTIPLY: alu_result = alu_operand1 * alu_operand2;
            OP_DIVIDE:   alu_result = (alu_operand2 == 8'd0) ? 8'd0 : alu_operand1 / alu_operand2;
            OP_AND:      alu_result = alu_operand1 & alu_operand2;
            OP_OR:       alu_result = alu_operand1 | alu_operand2;
            OP_NOT_OP1:  alu_result = ~alu_operand1;
            OP_NOT_OP2:  alu_result = ~alu_operand2;
            default:     alu_result = 8'd0;
        endcase
    end

    function automatic logic [7:0] ref_res(input int op, input int a, input int b, input int imm);
        int t;
        case (op)
            0:       t = imm;
            1:       t = (a + b) % 256;
            2:       t = (a - b + 256) % 256;
            3:       t = (a * b) % 256;
            4:       t = (b == 0) ? 0 : a / b;
            5:       t = a & b;
            6:       t = a | b;
            7:       t = 255 - a;
            8:       t = 255 - b;
            default: t = 0;
        endcase
        return t[7:0];
    endfunction

    function automatic logic [15:0] mk_ldi(input int rd, input int imm);
        logic [1:0] r;
        logic [7:0] v;
        r = rd[1:0];
        v = imm[7:0];
        return {4'b0000, r, 2'b00, v};
    endfunction

    function automatic logic [15:0] mk_alu(input int op, input int rd, input int rs1, input int rs2);
        logic [3:0] o;
        logic [1:0] d, s1, s2;
        o = op[3:0]; d = rd[1:0]; s1 = rs1[1:0]; s2 = rs2[1:0];
        return {o, d, s1, s2, 6'b000000};
    endfunction

    // Entered and left just after a falling edge.
    task automatic send(input logic [15:0] ins, input int stall);
        int         op, rd, rs1, rs2, n;
        logic [7:0] a, b, exp;
        op  = int'(ins[15:12]);
        rd  = int'(ins[11:10]);
        rs1 = int'(ins[9:8]);
        rs2 = int'(ins[7:6]);
        a   = mdl[rs1];
        b   = mdl[rs2];
        exp = ref_res(op, int'(a), int'(b), int'(ins[7:0]));
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout instr_ready=%b expected 1", instr_ready);
            return;
        end
        instr       = ins;
        instr_valid = 1'b1;
        res_ready   = (stall == 0);
        @(posedge clk);
        acc_time = $time;
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        if (op >= 9) begin
            checks++;
            if (illegal !== 1'b1 || instr_ready !== 1'b1 || res_valid !== 1'b0) begin
                errors++;
                $display("FAIL illegal_pulse illegal=%b ready=%b res_valid=%b expected 1 1 0",
                         illegal, instr_ready, res_valid);
            end
            @(negedge clk);
            checks++;
            if (illegal !== 1'b0) begin
                errors++;
                $display("FAIL illegal_width illegal=%b expected 0", illegal);
            end
            return;
        end
        if (op != 0) begin
            checks++;
            if (alu_opcode !== op[3:0] || alu_operand1 !== a || alu_operand2 !== b || res_valid !== 1'b0) begin
                errors++;
                $display("FAIL exec_drive op=%h opd1=%h opd2=%h rv=%b expected %h %h %h 0",
                         alu_opcode, alu_operand1, alu_operand2, res_valid, op[3:0], a, b);
            end
            @(negedge clk);
        end
        checks++;
        if (res_valid !== 1'b1 || res_data !== exp || res_rd !== rd[1:0]) begin
            errors++;
            $display("FAIL result ins=%h valid=%b data=%h rd=%0d expected 1 %h %0d",
                     ins, res_valid, res_data, res_rd, exp, rd);
        end
        last_res = res_data;
`ifdef ALU_ISSUE_FLAGS_EN
        checks++;
        if (res_zero !== (exp == 8'd0) || res_divz !== (op == 4 && b == 8'd0)) begin
            errors++;
            $display("FAIL flags zero=%b divz=%b expected %b %b",
                     res_zero, res_divz, (exp == 8'd0), (op == 4 && b == 8'd0));
        end
`endif
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp || instr_ready !== 1'b0 || alu_opcode !== 4'd0) begin
                errors++;
                $display("FAIL wb_hold valid=%b data=%h ready=%b opc=%h expected 1 %h 0 0",
                         res_valid, res_data, instr_ready, alu_opcode, exp);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        mdl[rd] = exp;
        checks++;
        if (res_valid !== 1'b0 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL wb_release valid=%b ready=%b expected 0 1", res_valid, instr_ready);
        end
    endtask

    task automatic check_regs();
        for (int r = 0; r < 4; r++) begin
            send(mk_alu(6, r, r, r), 0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_valid = 1'b0; instr = 16'h0; res_ready = 1'b1;
        for (int i = 0; i < 4; i++) mdl[i] = 8'd0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b0 || res_valid !== 1'b0 || illegal !== 1'b0 || alu_opcode !== 4'd0 ||
            alu_operand1 !== 8'd0 || alu_operand2 !== 8'd0 || res_data !== 8'd0 || res_rd !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs rdy=%b rv=%b ill=%b opc=%h o1=%h o2=%h d=%h rd=%0d expected all 0",
                     instr_ready, res_valid, illegal, alu_opcode, alu_operand1, alu_operand2, res_data, res_rd);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release instr_ready=%b expected 1", instr_ready);
        end
        check_regs();
    endtask

    task automatic test_ldi_add();
        time t0;
        send(mk_ldi(1, 7), 0);
        send(mk_ldi(2, 5), 0);
        send(mk_alu(1, 0, 1, 2), 0);
        t0 = acc_time;
        checks++;
        if (last_res !== 8'd12) begin
            errors++;
            $display("FAIL add_basic got %0d expected 12", last_res);
        end
        send(mk_alu(2, 3, 1, 2), 0);
        checks++;
        if ((acc_time - t0) / 10 != 3) begin
            errors++;
            $display("FAIL alu_throughput gap=%0d expected 3", (acc_time - t0) / 10);
        end
    endtask

    task automatic test_wrap_mul();
        send(mk_ldi(1, 200), 0);
        send(mk_ldi(2, 100), 0);
        send(mk_alu(1, 3, 1, 2), 0);
        checks++;
        if (last_res !== 8'd44) begin
            errors++;
            $display("FAIL add_wrap got %0d expected 44", last_res);
        end
        send(mk_alu(3, 3, 1, 2), 0);
        checks++;
        if (last_res !== 8'h20) begin
            errors++;
            $display("FAIL mul_trunc got %h expected 20", last_res);
        end
        send(mk_alu(1, 1, 1, 1), 0);
    endtask

    task automatic test_divide_zero();
        send(mk_ldi(1, 9), 0);
        send(mk_ldi(2, 0), 0);
        send(mk_alu(4, 0, 1, 2), 0);
        checks++;
        if (last_res !== 8'd0) begin
            errors++;
            $display("FAIL div_zero got %0d expected 0", last_res);
        end
        send(mk_ldi(2, 4), 0);
        send(mk_alu(4, 0, 1, 2), 0);
    endtask

    task automatic test_stall();
        send(mk_ldi(3, 8'hA5), 5);
        send(mk_alu(5, 2, 3, 3), 5);
        send(mk_alu(1, 2, 2, 2), 3);
        check_regs();
    endtask

    task automatic test_illegal();
        send(16'hB123, 0);
        for (int i = 9; i < 16; i++) begin
            send({i[3:0], 12'($urandom)}, 0);
        end
        check_regs();
    endtask

    task automatic test_reset_exec();
        send(mk_ldi(1, 50), 0);
        send(mk_ldi(2, 3), 0);
        instr = mk_alu(2, 0, 1, 2);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        checks++;
        if (alu_opcode !== OP_SUBTRACT) begin
            errors++;
            $display("FAIL sub_exec opc=%h expected 2", alu_opcode);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b0 || res_valid !== 1'b0 || illegal !== 1'b0 || alu_opcode !== 4'd0 ||
            alu_operand1 !== 8'd0 || alu_operand2 !== 8'd0 || res_data !== 8'd0 || res_rd !== 2'd0) begin
            errors++;
            $display("FAIL reset_in_exec rdy=%b rv=%b ill=%b opc=%h o1=%h o2=%h d=%h rd=%0d expected all 0",
                     instr_ready, res_valid, illegal, alu_opcode, alu_operand1, alu_operand2, res_data, res_rd);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) mdl[i] = 8'd0;
        @(negedge clk);
        check_regs();
    endtask

    task automatic test_back_to_back();
        time t0;
        send(mk_ldi(0, 17), 0);
        t0 = acc_time;
        send(mk_ldi(1, 34), 0);
        checks++;
        if ((acc_time - t0) / 10 != 2) begin
            errors++;
            $display("FAIL ldi_throughput gap=%0d expected 2", (acc_time - t0) / 10);
        end
        send(mk_alu(1, 2, 0, 1), 0);
        send(mk_alu(1, 2, 2, 2), 0);
    endtask

    task automatic test_random();
        int op;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) < 3) begin
                send(mk_ldi($urandom_range(0, 3), $urandom_range(0, 255)), $urandom_range(0, 2));
            end else begin
                op = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(1, 8);
                send(mk_alu(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)),
                     $urandom_range(0, 2));
            end
        end
        check_regs();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ldi_add();
        test_wrap_mul();
        test_divide_zero();
        test_stall();
        test_illegal();
        test_reset_exec();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
